sift_key_scheduler: RTL and testbench

//  Sequences the per-frame basis-sifting datapath. Accepts one frame of N qubits

---
 rtl/sift_key_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_sift_key_scheduler.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sift_key_scheduler.sv
// Per-frame sequencer for the basis-sifting datapath; compacts sifted bits into KEY_W-bit words.
// Optional `SIFT_STATS_EN adds stat_frames/stat_bits counters.
module sift_key_scheduler #(
    parameter int N        = 80,
    parameter int KEY_W    = 32,
    parameter int SIFT_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frm_valid,
    output logic             frm_ready,
    input  logic [2*N-1:0]   frm_qubit,
    input  logic [N-1:0]     frm_r_bases,
    input  logic [N-1:0]     frm_s_bases,
    output logic [2*N-1:0]   sift_qubit,
    output logic [N-1:0]     sift_r_bases,
    output logic [N-1:0]     sift_s_bases,
    input  logic [N-1:0]     sift_valid_in,
    input  logic [N-1:0]     sift_key_in,
    input  logic             flush,
    output logic [KEY_W-1:0] key_data,
    output logic             key_valid,
    input  logic             key_ready,
    output logic [5:0]       key_fill,
    output logic             frame_done,
    output logic             busy
`ifdef SIFT_STATS_EN
    ,
    output logic [31:0]      stat_frames,
    output logic [31:0]      stat_bits
`endif
);
    // state | meaning
    // IDLE  | frm_ready high, waiting for a frame
    // LOAD  | frame held on sift_* for the datapath
    // WAIT  | counting down the datapath latency, then snapshot results
    // SCAN  | one snapshot bit per cycle into the accumulator
    // DONE  | frame_done pulse, optional flush of the partial word
    typedef enum logic [2:0] {IDLE, LOAD, WAIT, SCAN, DONE} state_t;

    localparam int IDX_W = $clog2(N);
    localparam int CNT_W = (SIFT_LAT > 1) ? $clog2(SIFT_LAT + 1) : 1;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   wait_cnt;
    logic [IDX_W-1:0]   idx;
    logic [N-1:0]       snap_valid, snap_key;
    logic [KEY_W-1:0]   acc, acc_ins;
    logic [5:0]         fill;
    logic               flush_seen;

    logic hs, take, word_done, stall, slot_free, flush_emit;

    always_comb begin
        state_nxt  = state;
        hs         = 1'b0;
        take       = 1'b0;
        word_done  = 1'b0;
        stall      = 1'b0;
        flush_emit = 1'b0;
        slot_free  = !key_valid || key_ready;
        acc_ins    = acc | (KEY_W'(snap_key[idx]) << fill);
        case (state)
            IDLE: begin
                hs = frm_valid && frm_ready;
                if (hs) state_nxt = LOAD;
            end
            LOAD: state_nxt = WAIT;
            WAIT: if (wait_cnt == CNT_W'(1)) state_nxt = SCAN;
            SCAN: begin
                take      = snap_valid[idx];
                word_done = take && (fill == 6'(KEY_W - 1));
                // a completing word with the output slot still occupied freezes the scan
                if (word_done && !slot_free) stall = 1'b1;
                else if (idx == IDX_W'(N - 1)) state_nxt = DONE;
            end
            DONE: begin
                if ((flush_seen || flush) && fill != 6'd0) begin
                    flush_emit = slot_free;
                    if (slot_free) state_nxt = IDLE;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            frm_ready    <= 1'b0;
            frame_done   <= 1'b0;
            sift_qubit   <= '0;
            sift_r_bases <= '0;
            sift_s_bases <= '0;
            wait_cnt     <= '0;
            idx          <= '0;
            snap_valid   <= '0;
            snap_key     <= '0;
            acc          <= '0;
            fill         <= '0;
            flush_seen   <= 1'b0;
            key_data     <= '0;
            key_valid    <= 1'b0;
            key_fill     <= '0;
        end else begin
            state      <= state_nxt;
            frm_ready  <= (state_nxt == IDLE);
            frame_done <= (state_nxt == DONE) && (state != DONE);
            if (key_valid && key_ready) key_valid <= 1'b0;
            if (hs) begin
                sift_qubit   <= frm_qubit;
                sift_r_bases <= frm_r_bases;
                sift_s_bases <= frm_s_bases;
                flush_seen   <= flush;
            end else if (state != IDLE && flush) begin
                flush_seen <= 1'b1;
            end
            case (state)
                LOAD: wait_cnt <= CNT_W'(SIFT_LAT);
                WAIT: begin
                    wait_cnt <= wait_cnt - CNT_W'(1);
                    if (wait_cnt == CNT_W'(1)) begin
                        snap_valid <= sift_valid_in;
                        // mask so undefined key bits never enter the accumulator
                        snap_key   <= sift_key_in & sift_valid_in;
                        idx        <= '0;
                    end
                end
                SCAN: if (!stall) begin
                    idx <= idx + IDX_W'(1);
                    if (word_done) begin
                        key_data  <= acc_ins;
                        key_valid <= 1'b1;
                        key_fill  <= 6'(KEY_W);
                        acc       <= '0;
                        fill      <= '0;
                    end else if (take) begin
                        acc  <= acc_ins;
                        fill <= fill + 6'd1;
                    end
                end
                DONE: begin
                    if (flush_emit) begin
                        key_data  <= acc;
                        key_valid <= 1'b1;
                        key_fill  <= fill;
                        acc       <= '0;
                        fill      <= '0;
                    end
                    if (state_nxt == IDLE) flush_seen <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef SIFT_STATS_EN
    function automatic logic [31:0] popcount(input logic [N-1:0] v);
        logic [31:0] c;
        c = '0;
        for (int i = 0; i < N; i++) c = c + 32'(v[i]);
        return c;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_frames <= '0;
            stat_bits   <= '0;
        end else begin
            if (state_nxt == DONE && state != DONE) stat_frames <= stat_frames + 32'd1;
            if (state == WAIT && wait_cnt == CNT_W'(1))
                stat_bits <= stat_bits + popcount(sift_valid_in);
        end
    end
`endif
endmodule

// File: tb/tb_sift_key_scheduler.sv
// Scoreboard bench for sift_key_scheduler with a one-cycle model of the sift datapath.
// Stat counters are checked when SIFT_STATS_EN is defined.
module tb_sift_key_scheduler;
    localparam int N        = 80;
    localparam int KEY_W    = 32;
    localparam int SIFT_LAT = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n, frm_valid, frm_ready, flush, key_valid, frame_done, busy;
    logic             key_ready = 1'b1;
    logic [2*N-1:0]   frm_qubit, sift_qubit;
    logic [N-1:0]     frm_r_bases, frm_s_bases, sift_r_bases, sift_s_bases;
    logic [N-1:0]     dp_valid, dp_key;
    logic [KEY_W-1:0] key_data;
    logic [5:0]       key_fill;
`ifdef SIFT_STATS_EN
    logic [31:0]      stat_frames, stat_bits;
`endif

    sift_key_scheduler #(.N(N), .KEY_W(KEY_W), .SIFT_LAT(SIFT_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .frm_valid(frm_valid), .frm_ready(frm_ready),
        .frm_qubit(frm_qubit), .frm_r_bases(frm_r_bases), .frm_s_bases(frm_s_bases),
        .sift_qubit(sift_qubit), .sift_r_bases(sift_r_bases), .sift_s_bases(sift_s_bases),
        .sift_valid_in(dp_valid), .sift_key_in(dp_key), .flush(flush),
        .key_data(key_data), .key_valid(key_valid), .key_ready(key_ready),
        .key_fill(key_fill), .frame_done(frame_done), .busy(busy)
`ifdef SIFT_STATS_EN
        , .stat_frames(stat_frames), .stat_bits(stat_bits)
`endif
    );

    function automatic logic [N-1:0] code_lsb(input logic [2*N-1:0] q);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = q[2*i];
        return r;
    endfunction

    // sift datapath model: one register stage, valid where bases agree
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_valid <= '0;
            dp_key   <= '0;
        end else begin
            dp_valid <= ~(sift_r_bases ^ sift_s_bases);
            dp_key   <= code_lsb(sift_qubit);
        end
    end

    int checks = 0, failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    logic [KEY_W+5:0] exp_q[$];
    logic [KEY_W-1:0] m_acc = '0;
    int               m_fill = 0;
    int               st_frames = 0, st_bits = 0;
    int               exp_done = 0, done_count = 0;
    int               rdy_mode = 0;
    int               cyc;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       key_ready = 1'b1;
            1:       key_ready = 1'b0;
            default: key_ready = 1'($urandom_range(0, 1));
        endcase
    end

    logic             prev_hold = 1'b0;
    logic [KEY_W-1:0] prev_data = '0;
    always @(negedge clk) begin
        logic [KEY_W+5:0] e;
        if (rst_n) begin
            if (prev_hold) begin
                check_eq("hold_valid", 64'(key_valid), 64'(1));
                check_eq("hold_data", 64'(key_data), 64'(prev_data));
            end
            if (key_valid && key_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_word", 64'(exp_q.size()), 64'(1));
                end else begin
                    e = exp_q.pop_front();
                    check_eq("key_data", 64'(key_data), 64'(e[KEY_W-1:0]));
                    check_eq("key_fill", 64'(key_fill), 64'(e[KEY_W+5:KEY_W]));
                end
            end
            if (frame_done) done_count++;
            prev_hold = key_valid && !key_ready;
            prev_data = key_data;
        end else begin
            prev_hold = 1'b0;
        end
    end

    function automatic logic [N-1:0] rnd_n();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[N-1:0];
    endfunction

    function automatic logic [2*N-1:0] rnd_q();
        logic [191:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return t[2*N-1:0];
    endfunction

    function automatic logic [N-1:0] low_ones(input int k);
        logic [N-1:0] m;
        m = '0;
        for (int i = 0; i < k; i++) m[i] = 1'b1;
        return m;
    endfunction

    task automatic finish_now();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "bench aborted");
    endtask

    task automatic start_frame(input logic [N-1:0] r, input logic [N-1:0] s,
                               input logic [2*N-1:0] q, input logic fl);
        logic [N-1:0] v;
        int t;
        v = ~(r ^ s);
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                m_acc[m_fill] = q[2*i];
                m_fill++;
                if (m_fill == KEY_W) begin
                    exp_q.push_back({6'(KEY_W), m_acc});
                    m_acc  = '0;
                    m_fill = 0;
                end
            end
        end
        if (fl && m_fill > 0) begin
            exp_q.push_back({6'(m_fill), m_acc});
            m_acc  = '0;
            m_fill = 0;
        end
        st_bits += $countones(v);
        frm_valid   = 1'b1;
        frm_r_bases = r;
        frm_s_bases = s;
        frm_qubit   = q;
        flush       = fl;
        t = 0;
        @(negedge clk);
        while (!frm_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!frm_ready) begin
            check_eq("frm_handshake", 64'(frm_ready), 64'(1));
            finish_now();
        end
        @(posedge clk);
        #1;
        frm_valid   = 1'b0;
        flush       = 1'b0;
        frm_qubit   = rnd_q();
        frm_r_bases = rnd_n();
        frm_s_bases = rnd_n();
    endtask

    task automatic wait_done(output int c);
        c = 1;
        while (!frame_done && c < 2000) begin
            @(posedge clk);
            #1;
            c++;
        end
        check_eq("frame_done_seen", 64'(frame_done), 64'(1));
        st_frames++;
        exp_done++;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int t;
        rdy_mode = 0;
        t = 0;
        while (exp_q.size() > 0 && t < 500) begin
            @(posedge clk);
            t++;
        end
        repeat (3) @(posedge clk);
        #1;
        check_eq("drain_queue", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic do_reset();
        check_eq("pre_reset_queue", 64'(exp_q.size()), 64'(0));
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        m_acc     = '0;
        m_fill    = 0;
        st_frames = 0;
        st_bits   = 0;
        exp_q.delete();
    endtask

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, "_frm_ready"}, 64'(frm_ready), 64'(0));
        check_eq({tag, "_key_valid"}, 64'(key_valid), 64'(0));
        check_eq({tag, "_key_data"}, 64'(key_data), 64'(0));
        check_eq({tag, "_key_fill"}, 64'(key_fill), 64'(0));
        check_eq({tag, "_busy"}, 64'(busy), 64'(0));
        check_eq({tag, "_frame_done"}, 64'(frame_done), 64'(0));
        check_eq({tag, "_sift_qubit"}, 64'(sift_qubit[63:0]), 64'(0));
    endtask

    initial begin
        logic [2*N-1:0] q_alt;
        logic [N-1:0]   ones;
        rst_n = 1'b0; frm_valid = 1'b0; flush = 1'b0;
        frm_qubit = '0; frm_r_bases = '0; frm_s_bases = '0;
        ones = '1;
        q_alt = '0;
        for (int i = 0; i < N; i++) q_alt[2*i] = 1'(i % 2);
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst_n = 1'b1;

        // all-zero frame: two zero words, 16 bits carried, DONE on cycle N+2+SIFT_LAT
        start_frame('0, '0, '0, 1'b0);
        wait_done(cyc);
        check_eq("done_latency", 64'(cyc), 64'(N + 2 + SIFT_LAT));
        drain();
        do_reset();

        // alternating codes with flush: AAAAAAAA x2 then 0000AAAA/16
        start_frame(ones, ones, q_alt, 1'b1);
        wait_done(cyc);
        drain();
        // flush with nothing accumulated emits nothing
        start_frame('0, ones, rnd_q(), 1'b1);
        wait_done(cyc);
        // carry 16 bits, then a frame with no agreeing bases, then flush the carry
        start_frame('0, ~low_ones(16), rnd_q(), 1'b0);
        wait_done(cyc);
        start_frame('0, ones, rnd_q(), 1'b0);
        wait_done(cyc);
        check_eq("no_sift_no_word", 64'(key_valid), 64'(0));
        start_frame('0, ones, rnd_q(), 1'b1);
        wait_done(cyc);
        drain();

        // sink stalls for 40 cycles while the scan wants a second word
        fork
            begin
                start_frame(ones, ones, rnd_q(), 1'b0);
                wait_done(cyc);
            end
            begin
                repeat (30) @(posedge clk);
                rdy_mode = 1;
                repeat (40) @(posedge clk);
                rdy_mode = 0;
            end
        join
        check_eq("stall_extends_scan", 64'(cyc > N + 2 + SIFT_LAT), 64'(1));
        drain();

        // random frames with random backpressure
        rdy_mode = 2;
        for (int k = 0; k < 4; k++) begin
            start_frame(rnd_n(), rnd_n(), rnd_q(), 1'($urandom_range(0, 1)));
            wait_done(cyc);
        end
        drain();

        // empty the carry, then reset mid-scan with 20 bits accumulated
        start_frame('0, ones, rnd_q(), 1'b1);
        wait_done(cyc);
        drain();
        start_frame('0, ~low_ones(20), rnd_q(), 1'b0);
        repeat (30) @(posedge clk);
        #1;
        check_eq("midscan_busy", 64'(busy), 64'(1));
        rst_n = 1'b0;
        #1;
        check_zero_outputs("midscan_reset");
        m_acc  = '0;
        m_fill = 0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        start_frame('0, ~low_ones(8), rnd_q(), 1'b1);
        wait_done(cyc);
        drain();
        do_reset();

        // three frames of 40 sifted bits each
        for (int k = 0; k < 3; k++) begin
            start_frame('0, ~low_ones(40), rnd_q(), 1'b0);
            wait_done(cyc);
        end
        drain();
`ifdef SIFT_STATS_EN
        check_eq("stat_frames", 64'(stat_frames), 64'(st_frames));
        check_eq("stat_bits", 64'(stat_bits), 64'(st_bits));
`endif
        check_eq("frame_done_count", 64'(done_count), 64'(exp_done));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        check_eq("global_timeout", 64'(0), 64'(1));
        finish_now();
    end
endmodule
